// File: rtl/tdc_edge_gen.sv
// -----------------------------------------------------------------------------
// tdc_edge_gen
//
// Purpose:
//   Transmit-side stimulus for the TDC path. Emits bursts of start/stop edge
//   pairs whose rising edges are separated by an exact number of clock cycles.
//   start_o/stop_o feed the 2-bit start/stop input of the TDC tile
//   (bit0 = start, bit1 = stop), so the TDC can be characterised on-chip
//   against known intervals.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   go          in   start a burst (sampled in IDLE only)
//   abort       in   terminate a burst immediately (RUN/DONE)
//   cfg_delay   in   D: start-rise to stop-rise distance in cycles
//   cfg_width   in   W: pulse high time; 0 behaves as 1
//   cfg_period  in   P: idle cycles appended after each pair
//   cfg_count   in   N: pairs per burst; 0 means none
//   start_o     out  start edge to the TDC (direct flop output)
//   stop_o      out  stop edge to the TDC (direct flop output)
//   busy        out  high while in RUN
//   done        out  one-cycle pulse on burst completion
//   pair_idx    out  index of the current or last pair
//
// Build option:
//   TDC_EDGE_GEN_SWEEP_EN - when defined, the latched delay increments by one
//   (saturating) at every pair boundary, so one burst sweeps the TDC
//   transfer curve. When undefined no sweep logic exists.
// -----------------------------------------------------------------------------
module tdc_edge_gen #(
  parameter int DELAY_W  = 8,
  parameter int CNT_W    = 8,
  parameter int WIDTH_W  = 4,
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic                abort,
  input  logic [DELAY_W-1:0]  cfg_delay,
  input  logic [WIDTH_W-1:0]  cfg_width,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [CNT_W-1:0]    cfg_count,
  output logic                start_o,
  output logic                stop_o,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pair_idx
);

  // Phase counter must hold D+We+P-1 without wrapping: two guard bits over
  // the widest of the three fields are enough for the sum of all three.
  localparam int MAX_DW = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;
  localparam int MAX_W  = (MAX_DW > PERIOD_W) ? MAX_DW : PERIOD_W;
  localparam int T_W    = MAX_W + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]          state_reg,    state_next;
  logic [T_W-1:0]      t_reg,        t_next;
  logic [DELAY_W-1:0]  d_reg,        d_next;
  logic [WIDTH_W-1:0]  we_reg,       we_next;
  logic [PERIOD_W-1:0] p_reg,        p_next;
  logic [CNT_W-1:0]    n_reg,        n_next;
  logic [CNT_W-1:0]    pair_idx_reg, pair_idx_next;
  logic                start_reg,    start_next;
  logic                stop_reg,     stop_next;
  logic                busy_reg,     busy_next;
  logic                done_reg,     done_next;

  // Last phase of the current pair (We >= 1, so this never underflows).
  logic [T_W-1:0] last_t;
  assign last_t = T_W'(d_reg) + T_W'(we_reg) + T_W'(p_reg) - T_W'(1);

  // Pulse levels for phase t of a pair: {stop, start}.
  function automatic logic [1:0] pulse_at(input logic [T_W-1:0] t,
                                          input logic [T_W-1:0] d,
                                          input logic [T_W-1:0] we);
    logic s_start;
    logic s_stop;
    s_start = (t < we);
    s_stop  = (t >= d) && (t < d + we);
    return {s_stop, s_start};
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    t_next        = t_reg;
    d_next        = d_reg;
    we_next       = we_reg;
    p_next        = p_reg;
    n_next        = n_reg;
    pair_idx_next = pair_idx_reg;

    case (state_reg)
      S_IDLE: begin
        // abort has priority over go in IDLE
        if (go && !abort) begin
          d_next        = cfg_delay;
          we_next       = (cfg_width == '0) ? WIDTH_W'(1) : cfg_width;
          p_next        = cfg_period;
          n_next        = cfg_count;
          pair_idx_next = '0;
          t_next        = '0;
          state_next    = (cfg_count == '0) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_next = S_IDLE;
          t_next     = '0;
        end else if (t_reg == last_t) begin
          t_next = '0;
          if (pair_idx_reg == n_reg - CNT_W'(1)) begin
            state_next = S_DONE;
          end else begin
            pair_idx_next = pair_idx_reg + CNT_W'(1);
`ifdef TDC_EDGE_GEN_SWEEP_EN
            // Next pair uses one more cycle of delay, saturating at full scale.
            d_next = (d_reg == '1) ? d_reg : d_reg + DELAY_W'(1);
`else
            d_next = d_reg;
`endif
          end
        end else begin
          t_next = t_reg + T_W'(1);
        end
      end

      S_DONE: begin
        // Always a single cycle; go is not sampled here, abort lands in
        // IDLE just the same.
        state_next = S_IDLE;
        t_next     = '0;
      end

      default: begin
        state_next = S_IDLE;
        t_next     = '0;
      end
    endcase
  end

  // Output levels are computed from the next state/phase so the flops
  // themselves carry start_o/stop_o with no gating after the register.
  always_comb begin
    logic [1:0] lv;
    lv = pulse_at(t_next, T_W'(d_next), T_W'(we_next));
    start_next = 1'b0;
    stop_next  = 1'b0;
    if (state_next == S_RUN) begin
      start_next = lv[0];
      stop_next  = lv[1];
    end
    busy_next = (state_next == S_RUN);
    done_next = (state_next == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      t_reg        <= '0;
      d_reg        <= '0;
      we_reg       <= '0;
      p_reg        <= '0;
      n_reg        <= '0;
      pair_idx_reg <= '0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      t_reg        <= t_next;
      d_reg        <= d_next;
      we_reg       <= we_next;
      p_reg        <= p_next;
      n_reg        <= n_next;
      pair_idx_reg <= pair_idx_next;
      start_reg    <= start_next;
      stop_reg     <= stop_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign start_o  = start_reg;
  assign stop_o   = stop_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign pair_idx = pair_idx_reg;

endmodule

// File: tb/tb_tdc_edge_gen.sv
// -----------------------------------------------------------------------------
// tb_tdc_edge_gen
//
// Scoreboard bench for tdc_edge_gen. Each stimulus task builds the complete
// expected output waveform of a burst from the pulse rules (per pair k:
// delay Dk, width We, period Dk+We+P) and queues one entry per clock cycle.
// A monitor pops one entry on every falling edge while entries are pending
// and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_tdc_edge_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic       abort;
  logic [7:0] cfg_delay;
  logic [3:0] cfg_width;
  logic [7:0] cfg_period;
  logic [7:0] cfg_count;
  logic       start_o;
  logic       stop_o;
  logic       busy;
  logic       done;
  logic [7:0] pair_idx;

  always #5 clk = ~clk;

  tdc_edge_gen #(
    .DELAY_W (8),
    .CNT_W   (8),
    .WIDTH_W (4),
    .PERIOD_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .abort     (abort),
    .cfg_delay (cfg_delay),
    .cfg_width (cfg_width),
    .cfg_period(cfg_period),
    .cfg_count (cfg_count),
    .start_o   (start_o),
    .stop_o    (stop_o),
    .busy      (busy),
    .done      (done),
    .pair_idx  (pair_idx)
  );

  typedef struct packed {
    int         tid;
    logic       start;
    logic       stop;
    logic       busy;
    logic       done;
    logic [7:0] idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   last_idx = 0;

  function automatic exp_t mk(input int tid, input bit s, input bit p,
                              input bit b, input bit d, input int idx);
    exp_t e;
    e.tid   = tid;
    e.start = s;
    e.stop  = p;
    e.busy  = b;
    e.done  = d;
    e.idx   = idx[7:0];
    return e;
  endfunction

  // Monitor: one comparison per cycle while expectations are pending.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({start_o, stop_o, busy, done, pair_idx} !==
          {mon_e.start, mon_e.stop, mon_e.busy, mon_e.done, mon_e.idx}) begin
        errors++;
        $display("FAIL outputs test=%0d t=%0t got start=%b stop=%b busy=%b done=%b idx=%0d expected start=%b stop=%b busy=%b done=%b idx=%0d",
                 mon_e.tid, $time, start_o, stop_o, busy, done, pair_idx,
                 mon_e.start, mon_e.stop, mon_e.busy, mon_e.done, mon_e.idx);
      end
    end
  end

  task automatic rand_cfg();
    cfg_delay  = 8'($urandom);
    cfg_width  = 4'($urandom);
    cfg_period = 8'($urandom);
    cfg_count  = 8'($urandom);
  endtask

  // Idle cycles: outputs stay zero, pair_idx holds.
  task automatic idle(input int n, input bit g, input bit a, input int tid);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mk(tid, 0, 0, 0, 0, last_idx));
      go    = g;
      abort = a;
      rand_cfg();
      @(posedge clk);
      #1;
    end
    go    = 1'b0;
    abort = 1'b0;
    $display("idle    test=%0d cycles=%0d go=%0b abort=%0b", tid, n, g, a);
  endtask

  // One burst issued in the current cycle. cut >= 0 asserts abort (or rst
  // when cut_rst) at a cycle inside the burst chosen from cut.
  task automatic burst(input int d, input int w, input int p, input int n,
                       input int cut_in, input bit cut_rst, input bit hold_go,
                       input int tid);
    exp_t lst[$];
    int   we;
    int   dk;
    int   cut;
    int   final_idx;
    we  = (w == 0) ? 1 : w;
    cut = -1;
    lst.push_back(mk(tid, 0, 0, 0, 0, last_idx));
    if (n == 0) begin
      lst.push_back(mk(tid, 0, 0, 0, 1, 0));
    end else begin
      for (int k = 0; k < n; k++) begin
        dk = d;
`ifdef TDC_EDGE_GEN_SWEEP_EN
        dk = (d + k > 255) ? 255 : d + k;
`endif
        for (int t = 0; t < dk + we + p; t++)
          lst.push_back(mk(tid, t < we, (t >= dk) && (t < dk + we), 1, 0, k));
      end
      lst.push_back(mk(tid, 0, 0, 0, 1, n - 1));
    end
    final_idx = (n == 0) ? 0 : n - 1;
    if (cut_in >= 0) begin
      cut = 1 + (cut_in % (lst.size() - 1));
      while (lst.size() > cut + 1) void'(lst.pop_back());
      final_idx = cut_rst ? 0 : int'(lst[cut].idx);
      lst.push_back(mk(tid, 0, 0, 0, 0, final_idx));
    end
    foreach (lst[i]) exp_q.push_back(lst[i]);

    go         = 1'b1;
    abort      = 1'b0;
    rst        = 1'b0;
    cfg_delay  = d[7:0];
    cfg_width  = w[3:0];
    cfg_period = p[7:0];
    cfg_count  = n[7:0];
    for (int i = 1; i < lst.size(); i++) begin
      @(posedge clk);
      #1;
      go    = hold_go;
      abort = (i == cut) && !cut_rst;
      rst   = (i == cut) && cut_rst;
      rand_cfg();
    end
    @(posedge clk);
    #1;
    go        = hold_go;
    abort     = 1'b0;
    rst       = 1'b0;
    last_idx  = final_idx;
    $display("burst   test=%0d D=%0d W=%0d P=%0d N=%0d cut=%0d rst=%0b hold=%0b cycles=%0d",
             tid, d, w, p, n, cut, cut_rst, hold_go, lst.size());
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, w, p, n, c;
    bit cr;
    rst   = 1'b1;
    go    = 1'b0;
    abort = 1'b0;
    rand_cfg();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    last_idx = 0;
    idle(2, 0, 0, 0);                         // reset state

    burst(3, 2, 4, 2, -1, 0, 0, 1);           // basic burst
    idle(2, 0, 0, 1);
    burst(0, 0, 0, 3, -1, 0, 0, 2);           // D=0, W=0, P=0
    idle(1, 0, 0, 2);
    burst(7, 1, 1, 0, -1, 0, 0, 3);           // zero count
    idle(1, 0, 0, 3);
    burst(5, 2, 2, 4, 5, 0, 0, 4);            // abort at cycle 6
    burst(5, 2, 2, 4, -1, 0, 0, 5);           // go right after abort
    idle(1, 0, 0, 5);
    burst(4, 3, 2, 3, 4, 1, 0, 6);            // rst at cycle 5
    idle(4, 1, 1, 7);                         // go + abort in IDLE
    idle(1, 0, 0, 7);
    burst(2, 5, 1, 2, -1, 0, 0, 8);           // D < W overlap
    idle(1, 0, 0, 8);
    burst(1, 1, 0, 2, -1, 0, 1, 9);           // go held through DONE
    burst(2, 1, 1, 1, -1, 0, 0, 10);
    idle(1, 0, 0, 10);
    burst(254, 1, 0, 3, -1, 0, 0, 11);        // sweep case
    idle(1, 0, 0, 11);

    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, 12);
      w = $urandom_range(0, 5);
      p = $urandom_range(0, 5);
      n = $urandom_range(0, 5);
      if ($urandom_range(0, 9) == 0) d = $urandom_range(200, 255);
      if ($urandom_range(0, 9) == 0) w = $urandom_range(6, 15);
      c  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1000) : -1;
      cr = 1'($urandom_range(0, 1));
      burst(d, w, p, n, c, cr, 0, 100 + i);
      idle($urandom_range(0, 2), 0, 0, 100 + i);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_edge_gen.md
Name: tdc_edge_gen

Overview:
- Digital-to-time stimulus generator; the transmit end of the TDC path.
- Emits programmable start/stop edge pairs separated by an exact number of clock cycles, in bursts.
- Outputs drive the 2-bit start/stop input of the TDC tile (bit0 = start, bit1 = stop), so the TDC can be characterised on-chip against known intervals.
- Sits inside the micro-tile container as a selectable project, or ahead of the TDC in place of the sensor.

Parameters:
- DELAY_W, 8, width of the start-to-stop delay field and latched delay register.
- CNT_W, 8, width of the burst count and pair index.
- WIDTH_W, 4, width of the pulse-width field.
- PERIOD_W, 8, width of the inter-pair gap field.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  starts a burst; sampled only in IDLE.
- abort  in  1  terminates a burst immediately.
- cfg_delay  in  DELAY_W  D: start-rise to stop-rise distance, in cycles.
- cfg_width  in  WIDTH_W  W: high time of each pulse; 0 is treated as 1.
- cfg_period  in  PERIOD_W  P: idle cycles appended after each pair.
- cfg_count  in  CNT_W  N: pairs per burst; 0 means none.
- start_o  out  1  start edge to the TDC.
- stop_o  out  1  stop edge to the TDC.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at burst completion.
- pair_idx  out  CNT_W  index of the current or last pair.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE. start_o, stop_o, busy, done = 0. pair_idx = 0. Internal counters = 0.
- FSM states are IDLE, RUN, DONE.
- IDLE, go=1, abort=0:
  - Latch D, We=max(W,1), P, N.
  - Clear pair_idx.
  - If N=0, go to DONE; otherwise go to RUN with phase counter t=0.
- Latched config is frozen for the whole burst; cfg_* changes during RUN or DONE have no effect.
- RUN output equations per cycle: start_o = (t < We); stop_o = (t >= D) && (t < D+We); busy = 1.
- start_o and stop_o must come straight from flops, with no combinational logic after the register. Implement them as registered next-state values so they are glitch-free at the TDC.
- Counter widths: t counts 0 to D+We+P-1. Size t at max(DELAY_W, WIDTH_W, PERIOD_W)+2 bits; no wrap is allowed.
- Pair boundary (t = D+We+P-1):
  - If pair_idx = N-1, go to DONE.
  - Otherwise pair_idx increments, and t=0 on the next cycle.
- Pair repetition period is exactly D+We+P cycles.
- D=0: start and stop rise in the same cycle.
- D<We: the two pulses overlap.
- Timing from go: go sampled at cycle T gives the first start_o high at T+1 and the first stop_o rise at T+1+D.
- DONE: lasts exactly one cycle with done=1, busy=0, start_o=stop_o=0. It then returns to IDLE. go is ignored while in DONE.
- pair_idx holds its final value after DONE until the next accepted go.
- abort in RUN or DONE: next cycle is IDLE with all outputs 0 and no done pulse. pair_idx holds.
- abort and go high together in IDLE: abort wins and go is ignored.
- go held high: a new burst starts on the first IDLE cycle after DONE.
- rst has priority over everything; asserted mid-burst, the next cycle shows reset values.

Optional Feature:
- Macro: TDC_EDGE_GEN_SWEEP_EN.
- When defined, the latched D increments by 1 at each pair boundary within a burst, saturating at 2^DELAY_W-1. This lets one burst sweep the TDC transfer curve.
- Pair k uses delay D+k (saturated), and its period becomes D+k+We+P.
- When undefined, D is constant for the whole burst and no sweep logic is synthesised.

Test Plan:
- Basic burst: D=3, W=2, P=4, N=2, go at cycle 0.
  - start_o high cycles 1-2 and 10-11; stop_o high cycles 4-5 and 13-14.
  - busy high cycles 1-18; done=1 only at cycle 19; pair_idx=1 afterwards.
- Edge values: D=0, W=0, P=0, N=3.
  - start_o and stop_o both high for single cycles 1, 2, 3 (period 1).
  - done at cycle 4.
- Zero count: N=0, go at cycle 0.
  - No pulses; done=1 at cycle 1; busy stays 0.
- Abort: D=5, W=2, P=2, N=4; abort at cycle 6.
  - Outputs 0 from cycle 7; no done pulse; pair_idx=0.
  - A new go at cycle 8 restarts with start_o high at cycle 9.
- Reset and config freeze: change cfg_delay mid-burst and confirm no effect; assert rst at cycle 5 and confirm all outputs 0 at cycle 6.
  - Also: go and abort together in IDLE produce no burst.
- Sweep (TDC_EDGE_GEN_SWEEP_EN defined): D=254, W=1, P=0, N=3.
  - stop_o rises 254, 255, 255 cycles after the respective start_o rises.
